// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the core datapath.
// A load/store is accepted over a valid/ready request channel, held for
// WAIT_CYCLES wait states, then performed against internal byte-addressed,
// little-endian storage. The result is reported by a one-cycle rsp_valid pulse.
// Supports byte/halfword/word access selected by RV32I funct3, with sign or
// zero extension on loads.
//
// Optional feature macro: DMEM_ERR_EN
//   defined   - misaligned halfword/word accesses and illegal funct3 are
//               rejected (rsp_err = 1, no write, rsp_rdata = 0).
//   undefined - rsp_err is tied to 0, misaligned accesses are aligned down,
//               and illegal funct3 is treated as a word access.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   req_valid   request present
//   req_ready   responder idle and able to accept
//   req_we      1 = store, 0 = load
//   req_funct3  RV32I load/store funct3
//   req_addr    byte address
//   req_wdata   store data (low bytes used for SB/SH)
//   rsp_valid   one-cycle response pulse
//   rsp_rdata   extended load data (0 for stores and errors), held until next response
//   rsp_err     request rejected, qualified by rsp_valid
module dmem_responder #(
    parameter int DATA_W      = 32,
    parameter int DM_ADDRESS  = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    localparam int WORDS = 1 << (DM_ADDRESS - 2);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic                    cap_we;
    logic [2:0]              cap_f3;
    logic [DM_ADDRESS-1:0]   cap_addr;
    logic [DATA_W-1:0]       cap_wdata;

    logic [DATA_W-1:0]       mem [WORDS];

    logic                    accept;
    logic                    enter_resp;
    logic                    a_we;
    logic [2:0]              a_f3;
    logic [DM_ADDRESS-1:0]   a_addr;
    logic [DATA_W-1:0]       a_wdata;
    logic                    legal;
    logic                    err;
    logic                    uns;
    logic [1:0]              size;
    logic [1:0]              off;
    logic [DM_ADDRESS-3:0]   word_idx;
    logic [DATA_W-1:0]       rword;
    logic [DATA_W-1:0]       shifted;
    logic [DATA_W-1:0]       ldata;
    logic [3:0]              be;
    logic [DATA_W-1:0]       wd;

    assign req_ready = (state == S_IDLE);
    assign accept    = req_valid && (state == S_IDLE);

    // The access happens on the edge that enters RESP. With zero wait states
    // that is the acceptance edge itself, so the live request is used there;
    // otherwise only the captured copy is used.
    assign enter_resp = reset &&
                        ((accept && (WAIT_CYCLES == 0)) ||
                         ((state == S_WAIT) && (cnt == 4'd1)));

    assign a_we    = (state == S_IDLE) ? req_we     : cap_we;
    assign a_f3    = (state == S_IDLE) ? req_funct3 : cap_f3;
    assign a_addr  = (state == S_IDLE) ? req_addr   : cap_addr;
    assign a_wdata = (state == S_IDLE) ? req_wdata  : cap_wdata;

    always_comb begin
        if (a_we) legal = (a_f3 == 3'b000) || (a_f3 == 3'b001) || (a_f3 == 3'b010);
        else      legal = (a_f3 == 3'b000) || (a_f3 == 3'b001) || (a_f3 == 3'b010) ||
                          (a_f3 == 3'b100) || (a_f3 == 3'b101);
        uns  = a_f3[2];
        off  = a_addr[1:0];
        err  = 1'b0;
`ifdef DMEM_ERR_EN
        size = a_f3[1:0];
        if (!legal ||
            ((size == 2'b01) && a_addr[0]) ||
            ((size == 2'b10) && (a_addr[1:0] != 2'b00)))
            err = 1'b1;
`else
        size = legal ? a_f3[1:0] : 2'b10;
        if (!legal) uns = 1'b0;
        if (size == 2'b01) off = {a_addr[1], 1'b0};
        else if (size == 2'b10) off = 2'b00;
`endif
    end

    assign word_idx = a_addr[DM_ADDRESS-1:2];
    assign rword    = mem[word_idx];
    assign shifted  = rword >> {off, 3'b000};

    always_comb begin
        case (size)
            2'b00:   ldata = uns ? {24'h0, shifted[7:0]}
                             : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   ldata = uns ? {16'h0, shifted[15:0]}
                             : {{16{shifted[15]}}, shifted[15:0]};
            default: ldata = rword;
        endcase
    end

    always_comb begin
        case (size)
            2'b00: begin
                be = 4'b0001 << off;
                wd = {4{a_wdata[7:0]}};
            end
            2'b01: begin
                be = 4'b0011 << off;
                wd = {2{a_wdata[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = a_wdata;
            end
        endcase
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (enter_resp && a_we && !err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) mem[word_idx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            cap_we    <= 1'b0;
            cap_f3    <= '0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
`ifdef DMEM_ERR_EN
            rsp_err   <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        cap_we    <= req_we;
                        cap_f3    <= req_funct3;
                        cap_addr  <= req_addr;
                        cap_wdata <= req_wdata;
                        cnt       <= WAIT_INIT;
                        if (WAIT_CYCLES == 0) state <= S_RESP;
                        else                  state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= S_RESP;
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
            if (enter_resp) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= (a_we || err) ? '0 : ldata;
`ifdef DMEM_ERR_EN
                rsp_err   <= err;
`endif
            end
        end
    end

`ifndef DMEM_ERR_EN
    assign rsp_err = 1'b0;
`endif

endmodule
